// File: rtl/serializer_pkg.sv
// serializer_pkg: shared constants, FSM state type and the length-code decode
// used by the serializer.
//   DATA_W  - parallel word width
//   MOD_W   - width of the length code (log2(DATA_W))
//   MIN_LEN - shortest length that is transmitted; shorter requests are dropped
//   CNT_W   - bit-counter width, wide enough to hold DATA_W
package serializer_pkg;

  localparam int DATA_W  = 16;
  localparam int MOD_W   = 4;
  localparam int MIN_LEN = 3;
  localparam int CNT_W   = MOD_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // A code of 0 stands for a full word; any other code is the length itself.
  function automatic logic [CNT_W-1:0] decode_len(input logic [MOD_W-1:0] mod);
    if (mod == '0) return CNT_W'(DATA_W);
    else           return {1'b0, mod};
  endfunction

endpackage

// File: rtl/serializer.sv
// serializer: parallel-to-serial converter. One request word plus a length
// code is captured while idle and its selected bits are shifted out one per
// clock on a single wire. busy_o back-pressures the producer for the whole
// burst; requests seen while busy are ignored.
//
// Ports:
//   clk_i          - clock, all logic on the rising edge
//   srst_i         - asynchronous active-low reset
//   data_i         - parallel word (DATA_W)
//   data_mod_i     - length code (MOD_W), 0 = full word
//   data_val_i     - request strobe
//   ser_data_o     - serial bit, 0 whenever not valid
//   ser_data_val_o - serial bit valid
//   busy_o         - burst in progress
//
// Build option:
//   SERIALIZER_LSB_FIRST_EN - when defined, bits leave starting at data_i[0]
//   and going upward; otherwise they leave starting at data_i[DATA_W-1].
//   Timing is identical in both builds.
module serializer
  import serializer_pkg::*;
(
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

`ifdef SERIALIZER_LSB_FIRST_EN
  localparam int OUT_BIT = 0;
`else
  localparam int OUT_BIT = DATA_W - 1;
`endif

  ser_state_e        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;

  ser_state_e        w_state_nxt;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_len;
  logic [DATA_W-1:0] w_shifted;

  assign w_len = decode_len(data_mod_i);

  // The outgoing bit always sits at OUT_BIT; shifting moves the next one in.
`ifdef SERIALIZER_LSB_FIRST_EN
  assign w_shifted = {1'b0, r_shreg[DATA_W-1:1]};
`else
  assign w_shifted = {r_shreg[DATA_W-2:0], 1'b0};
`endif

  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are decoded from registered state only, so they clear as soon as
  // reset asserts and never depend on the request inputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_cnt_nxt      = r_cnt;
    ser_data_o     = 1'b0;
    ser_data_val_o = 1'b0;
    busy_o         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (data_val_i && (w_len >= CNT_W'(MIN_LEN))) begin
          w_state_nxt = SHIFT;
          w_shreg_nxt = data_i;
          w_cnt_nxt   = w_len;
        end
      end
      SHIFT: begin
        ser_data_val_o = 1'b1;
        busy_o         = 1'b1;
        ser_data_o     = r_shreg[OUT_BIT];
        // r_cnt counts bits still to show, including the current one; the
        // last bit forces one idle cycle before the next request is taken.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_shreg_nxt = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;
  import serializer_pkg::*;

  logic              clk_i = 1'b0;
  logic              srst_i;
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  serializer dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: queue of bits still to appear; head is the bit on the wire now.
  bit q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mlen(input logic [MOD_W-1:0] m);
    return (m == 0) ? DATA_W : int'(m);
  endfunction

  task automatic check_out(input string tag);
    logic eb;
    eb = (q.size() > 0) ? q[0] : 1'b0;
    chk({tag, ".val"},  {31'd0, ser_data_val_o}, {31'd0, q.size() > 0});
    chk({tag, ".busy"}, {31'd0, busy_o},         {31'd0, q.size() > 0});
    chk({tag, ".bit"},  {31'd0, ser_data_o},     {31'd0, eb});
  endtask

  // One clock: drive inputs at negedge, advance the model at posedge,
  // compare just after the edge.
  task automatic cyc(input string tag, input logic v, input logic [DATA_W-1:0] d,
                     input logic [MOD_W-1:0] m);
    int l;
    @(negedge clk_i);
    data_val_i = v; data_i = d; data_mod_i = m;
    @(posedge clk_i);
    if (srst_i) begin
      if (q.size() > 0) begin
        void'(q.pop_front());
      end else if (v && mlen(m) >= MIN_LEN) begin
        l = mlen(m);
        for (int i = 0; i < l; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
          q.push_back(d[i]);
`else
          q.push_back(d[DATA_W-1-i]);
`endif
        end
      end
    end
    #1 check_out(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 16'h0, 4'h0);
  endtask

  int bursts;
  int run;
  int gaps_ok;

  initial begin
    srst_i = 1'b0; data_val_i = 1'b0; data_i = '0; data_mod_i = '0;

    // Reset held for 3 cycles with no requests.
    idle("rst", 3);
    @(negedge clk_i) srst_i = 1'b1;
    idle("post_rst", 2);

    // Full word, then idle.
    cyc("full", 1'b1, 16'h000A, 4'd0);
    idle("full", 17);

    // Short word, length 3.
    cyc("short", 1'b1, 16'hA000, 4'd3);
    idle("short", 4);

    // Length 15.
    cyc("len15", 1'b1, 16'h8001, 4'd15);
    idle("len15", 16);

    // Lengths 1 and 2 are dropped.
    cyc("drop1", 1'b1, 16'hFFFF, 4'd1);
    cyc("drop2", 1'b1, 16'hFFFF, 4'd2);
    idle("drop", 2);

    // Requests while busy, including the last-bit cycle, are ignored.
    cyc("ign", 1'b1, 16'h5A5A, 4'd5);
    for (int i = 0; i < 5; i++) cyc("ign_busy", 1'b1, 16'hFFFF, 4'd0);
    idle("ign", 2);
    cyc("reissue", 1'b1, 16'hFFFF, 4'd0);
    idle("reissue", 17);

    // Back-to-back with data_val_i held high: bursts of 4, one idle cycle apart.
    bursts = 0; run = 0; gaps_ok = 1;
    for (int i = 0; i < 25; i++) begin
      cyc("b2b", 1'b1, 16'(i * 16'h1357), 4'd4);
      if (busy_o) run++;
      else if (run != 0) begin
        if (run != 4) gaps_ok = 0;
        bursts++; run = 0;
      end else if (i != 0) gaps_ok = 0;
    end
    chk("b2b.bursts", 32'(bursts), 32'd5);
    chk("b2b.shape",  32'(gaps_ok), 32'd1);
    idle("b2b", 6);

    // Reset mid-burst clears outputs immediately, no resumption afterwards.
    cyc("mid", 1'b1, 16'hFFFF, 4'd0);
    idle("mid", 4);
    @(negedge clk_i);
    #2 srst_i = 1'b0;
    #1;
    q.delete();
    check_out("mid_async");
    idle("mid_rst", 2);
    @(negedge clk_i) srst_i = 1'b1;
    idle("mid_after", 20);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc("rand", ($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
    end
    idle("tail", 18);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter. Accepts one 16-bit word plus a length code and shifts the selected bits out one per clock, MSB first.
- Sits between a word-oriented producer and a single-wire bit sink.
- busy_o gives back-pressure to the producer.

Parameters:
- DATA_W, 16, parallel word width.
- MOD_W, 4, width of the length code, equal to log2(DATA_W).
- MIN_LEN, 3, smallest transmitted length; shorter requests are discarded.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- srst_i  input  1  reset; asynchronous, active-low (0 = reset).
- data_i  input  DATA_W  parallel word to serialize.
- data_mod_i  input  MOD_W  number of bits to send, taken from data_i[15] downward; 0 means all 16 bits.
- data_val_i  input  1  request strobe; data_i and data_mod_i are sampled when it is high.
- ser_data_o  output  1  serial bit.
- ser_data_val_o  output  1  ser_data_o is valid this cycle.
- busy_o  output  1  transmission in progress; requests are ignored.

Behaviour:
Reset:
- srst_i low forces ser_data_o=0, ser_data_val_o=0, busy_o=0, state IDLE and counters 0, immediately (asynchronous).
- Release is synchronous to clk_i.

Length decode:
- len = 16 if data_mod_i==0; otherwise len = data_mod_i.
- len 1 or 2 (< MIN_LEN): the request is dropped. No output and no busy.

States: IDLE, SHIFT.
IDLE:
- Accept when data_val_i=1 and len>=MIN_LEN.
- On acceptance, latch data_i into a shift register and len into a counter, then go to SHIFT.
- Outputs stay 0 in the acceptance cycle.
SHIFT:
- One bit per cycle, starting the cycle after acceptance: ser_data_o = data_i[15], then [14], and so on for exactly len cycles.
- ser_data_val_o=1 and busy_o=1 in every one of those len cycles.
- After the last bit, the next cycle returns to IDLE with ser_data_val_o=0, busy_o=0 and ser_data_o=0.

Latency and handshake:
- Latency is 1 cycle from acceptance to the first bit.
- Back-to-back words have a minimum gap of 1 idle cycle between bursts.
- data_val_i is ignored while busy_o=1, including the last-bit cycle. Inputs may change freely during SHIFT.
- ser_data_o is driven 0 whenever ser_data_val_o=0.

Boundaries:
- Reset mid-burst aborts at once; no partial completion afterwards.
- data_mod_i=15 sends bits 15..1.
- data_mod_i=3 sends bits 15..13.

Optional Feature:
- Macro: SERIALIZER_LSB_FIRST_EN.
- Defined: bits leave LSB first, starting at data_i[0] and going upward for len bits (data_mod_i=3 sends bits 0,1,2). All timing is unchanged.
- Undefined (default): MSB-first order as specified above.

Decomposition:
- Package serializer_pkg holds DATA_W, MOD_W, MIN_LEN, CNT_W (=MOD_W+1, able to hold 16) and the state enum (IDLE, SHIFT).
- Single flat module. The length decode is a small function in the package; no sub-module is warranted.

Test Plan:
- Reset then idle: srst_i low for 3 cycles, data_val_i=0 -> all outputs 0; asserting srst_i low mid-burst clears outputs in the same cycle.
- Full word: data_i=16'h000A, data_mod_i=0, data_val_i pulse -> next cycle starts 16 valid bits 0,0,0,0,0,0,0,0,0,0,0,0,1,0,1,0 with busy_o=1 throughout, then all outputs 0.
- Short word: data_i=16'hA000, data_mod_i=3 -> bits 1,0,1 over 3 cycles, then idle.
- Dropped requests: data_mod_i=1 and data_mod_i=2 with data_val_i=1 -> busy_o and ser_data_val_o stay 0.
- Ignore while busy: second data_val_i with data_i=16'hFFFF during a burst, including its last-bit cycle -> current burst unaltered and no second burst; re-issuing it after busy_o falls gives 16 ones.
- Back-to-back: data_val_i held high with data_mod_i=4 -> bursts of 4 valid cycles each separated by exactly 1 idle cycle.
